button_event_decoder: RTL and testbench

- Sits directly downstream of the Debouncer and consumes its clean, clock-synchronous level output.
- Turns that level into single-cycle event pulses: press, release, click, double-click and long-press.
- Consumers are UI or control FSMs that need discrete events rather than a level.
- Contains no filtering of its own: the input is already debounced.

---
 rtl/io_pkg.sv | 34 +++
 rtl/button_event_decoder_if.sv | 21 ++
 rtl/button_event_decoder_edge_detector.sv | 32 +++
 rtl/button_event_decoder.sv | 140 ++++++++++++++
 tb/tb_button_event_decoder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the io blocks: button FSM state encoding and the
// bit layout used when the five button event pulses are bundled into one vector.
package io_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRESS1 = 2'd1,
      ST_WAIT2  = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam int EV_PRESS   = 0;
   localparam int EV_RELEASE = 1;
   localparam int EV_CLICK   = 2;
   localparam int EV_DOUBLE  = 3;
   localparam int EV_LONG    = 4;
   localparam int EV_WIDTH   = 5;

   typedef logic [EV_WIDTH-1:0] event_vec_t;

   function automatic event_vec_t pack_events(input logic press, input logic rel,
                                              input logic click, input logic dbl,
                                              input logic long_p);
      event_vec_t ev;
      ev             = '0;
      ev[EV_PRESS]   = press;
      ev[EV_RELEASE] = rel;
      ev[EV_CLICK]   = click;
      ev[EV_DOUBLE]  = dbl;
      ev[EV_LONG]    = long_p;
      return ev;
   endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Bundle of the debounced level input and the decoded event outputs.
// master drives the level and observes events; slave is the decoder side.
interface button_event_decoder_if;
   logic i_level;
   logic o_held;
   logic o_press;
   logic o_release;
   logic o_click;
   logic o_double_click;
   logic o_long_press;

   modport master (
      output i_level,
      input  o_held, o_press, o_release, o_click, o_double_click, o_long_press
   );

   modport slave (
      input  i_level,
      output o_held, o_press, o_release, o_click, o_double_click, o_long_press
   );
endinterface

// File: rtl/button_event_decoder_edge_detector.sv
// Polarity-normalised level sampler: holds the previous sample and flags
// press (rise) / release (fall) edges of the current sample against it.
module edge_detector #(
   parameter logic p_ACTIVE_LOW = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_level,
   output logic o_sample,
   output logic o_held,
   output logic o_rise,
   output logic o_fall
);

   logic prev;

   assign o_sample = i_level ^ p_ACTIVE_LOW;

   // Reset value is "released" so a level already pressed at the first edge counts as a press.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         prev <= 1'b0;
      end else begin
         prev <= o_sample;
      end
   end

   assign o_held = prev;
   assign o_rise = o_sample & ~prev;
   assign o_fall = ~o_sample & prev;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into registered single-cycle press, release,
// click, double-click and long-press pulses using one shared interval counter.
module button_event_decoder
   import io_pkg::*;
#(
   parameter int   p_CNT_WIDTH    = 4,
   parameter int   p_LONG_TICKS   = 8,
   parameter int   p_DOUBLE_TICKS = 6,
   parameter logic p_ACTIVE_LOW   = 1'b0
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   button_event_decoder_if.slave bus
);

   localparam int CNT_MAX = (2 ** p_CNT_WIDTH) - 1;
   localparam logic [p_CNT_WIDTH-1:0] CNT_ONE  = p_CNT_WIDTH'(1);
   localparam logic [p_CNT_WIDTH-1:0] CNT_TOP  = p_CNT_WIDTH'(CNT_MAX);
   localparam logic [p_CNT_WIDTH:0]   LONG_LIM = (p_CNT_WIDTH + 1)'(p_LONG_TICKS);
   localparam logic [p_CNT_WIDTH:0]   DBL_LIM  = (p_CNT_WIDTH + 1)'(p_DOUBLE_TICKS);

   generate
      if (p_LONG_TICKS < 2 || p_LONG_TICKS > CNT_MAX) begin : g_bad_long
         $error("button_event_decoder: p_LONG_TICKS=%0d outside 2..%0d", p_LONG_TICKS, CNT_MAX);
      end
      if (p_DOUBLE_TICKS != 0 && (p_DOUBLE_TICKS < 2 || p_DOUBLE_TICKS > CNT_MAX)) begin : g_bad_dbl
         $error("button_event_decoder: p_DOUBLE_TICKS=%0d must be 0 or 2..%0d", p_DOUBLE_TICKS, CNT_MAX);
      end
   endgenerate

   logic sample, held, rise, fall;

   edge_detector #(
      .p_ACTIVE_LOW (p_ACTIVE_LOW)
   ) u_edge (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_level  (bus.i_level),
      .o_sample (sample),
      .o_held   (held),
      .o_rise   (rise),
      .o_fall   (fall)
   );

   state_t                 state, state_nxt;
   logic [p_CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_bump;
   logic [p_CNT_WIDTH:0]   cnt_inc;
   logic                   click_nxt, dbl_nxt, long_nxt;
   logic                   press_q, release_q, click_q, dbl_q, long_q;

   // One extra bit so the threshold compare cannot alias when cnt sits at its maximum.
   assign cnt_inc  = {1'b0, cnt} + (p_CNT_WIDTH + 1)'(1);
   assign cnt_bump = (cnt == CNT_TOP) ? cnt : cnt_inc[p_CNT_WIDTH-1:0];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      click_nxt = 1'b0;
      dbl_nxt   = 1'b0;
      long_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rise) begin
               state_nxt = ST_PRESS1;
               cnt_nxt   = CNT_ONE;
            end
         end
         ST_PRESS1: begin
            if (sample) begin
               if (cnt_inc == LONG_LIM) begin
                  state_nxt = ST_HOLD;
                  cnt_nxt   = '0;
                  long_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt_bump;
               end
            end else if (p_DOUBLE_TICKS == 0) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               click_nxt = 1'b1;
            end else begin
               state_nxt = ST_WAIT2;
               cnt_nxt   = CNT_ONE;
            end
         end
         ST_WAIT2: begin
            // A press on what would be the closing sample still wins as a double-click.
            if (sample) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = '0;
               dbl_nxt   = 1'b1;
            end else if (cnt_inc == DBL_LIM) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               click_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt_bump;
            end
         end
         ST_HOLD: begin
            if (fall) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         click_q   <= 1'b0;
         dbl_q     <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         press_q   <= rise;
         release_q <= fall;
         click_q   <= click_nxt;
         dbl_q     <= dbl_nxt;
         long_q    <= long_nxt;
      end
   end

   assign bus.o_held         = held;
   assign bus.o_press        = press_q;
   assign bus.o_release      = release_q;
   assign bus.o_click        = click_q;
   assign bus.o_double_click = dbl_q;
   assign bus.o_long_press   = long_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed and random gestures applied to a default build and an active-low,
// double-click-disabled build, each compared against a gesture-level reference model.
module tb_button_event_decoder;
   import io_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic level;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   button_event_decoder_if bif_a ();
   button_event_decoder_if bif_b ();

   assign bif_a.i_level = level;
   assign bif_b.i_level = ~level;

   button_event_decoder #(
      .p_CNT_WIDTH (4), .p_LONG_TICKS (8), .p_DOUBLE_TICKS (6), .p_ACTIVE_LOW (1'b0)
   ) dut_a (
      .i_clk (clk), .i_rst_n (rst_n), .bus (bif_a.slave)
   );

   button_event_decoder #(
      .p_CNT_WIDTH (4), .p_LONG_TICKS (8), .p_DOUBLE_TICKS (0), .p_ACTIVE_LOW (1'b1)
   ) dut_b (
      .i_clk (clk), .i_rst_n (rst_n), .bus (bif_b.slave)
   );

   // Reference model: run length of the current level plus the gesture phase.
   bit         m_prev   [2];
   int         m_run    [2];
   bit         m_first  [2];
   bit         m_pend   [2];
   bit         m_cons   [2];
   event_vec_t exp_ev   [2];
   bit         exp_held [2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_prev[k]   = 1'b0;
         m_run[k]    = 0;
         m_first[k]  = 1'b0;
         m_pend[k]   = 1'b0;
         m_cons[k]   = 1'b0;
         exp_ev[k]   = '0;
         exp_held[k] = 1'b0;
      end
   endtask

   task automatic model_step(input int k, input bit p);
      int         long_ticks;
      int         dbl_ticks;
      bit         rise, fall;
      event_vec_t ev;
      long_ticks = 8;
      dbl_ticks  = (k == 0) ? 6 : 0;
      ev    = '0;
      rise  = p && !m_prev[k];
      fall  = !p && m_prev[k];
      m_run[k] = (p == m_prev[k]) ? m_run[k] + 1 : 1;
      ev[EV_PRESS]   = rise;
      ev[EV_RELEASE] = fall;
      if (rise) begin
         if (m_pend[k]) begin
            ev[EV_DOUBLE] = 1'b1;
            m_pend[k] = 1'b0;
            m_cons[k] = 1'b1;
         end else begin
            m_first[k] = 1'b1;
         end
      end else if (p && m_first[k] && m_run[k] == long_ticks) begin
         ev[EV_LONG] = 1'b1;
         m_first[k] = 1'b0;
         m_cons[k]  = 1'b1;
      end
      if (fall) begin
         if (m_first[k]) begin
            m_first[k] = 1'b0;
            if (dbl_ticks == 0) ev[EV_CLICK] = 1'b1;
            else m_pend[k] = 1'b1;
         end
         m_cons[k] = 1'b0;
      end else if (!p && m_pend[k] && m_run[k] == dbl_ticks) begin
         ev[EV_CLICK] = 1'b1;
         m_pend[k] = 1'b0;
      end
      m_prev[k]   = p;
      exp_ev[k]   = ev;
      exp_held[k] = p;
   endtask

   task automatic check_dut(input int k, input string tag);
      event_vec_t obs;
      logic       held;
      if (k == 0) begin
         obs  = pack_events(bif_a.o_press, bif_a.o_release, bif_a.o_click,
                            bif_a.o_double_click, bif_a.o_long_press);
         held = bif_a.o_held;
      end else begin
         obs  = pack_events(bif_b.o_press, bif_b.o_release, bif_b.o_click,
                            bif_b.o_double_click, bif_b.o_long_press);
         held = bif_b.o_held;
      end
      checks++;
      assert (held === exp_held[k]) else begin
         errors++;
         $error("FAIL %s dut%0d held: observed %b expected %b", tag, k, held, exp_held[k]);
      end
      checks++;
      assert (obs === exp_ev[k]) else begin
         errors++;
         $error("FAIL %s dut%0d events{long,dbl,click,rel,press}: observed %b expected %b",
                tag, k, obs, exp_ev[k]);
      end
   endtask

   task automatic check_both(input string tag);
      check_dut(0, tag);
      check_dut(1, tag);
   endtask

   // Level changes one time unit after an edge; outputs are sampled there too.
   task automatic step(input bit b, input string tag);
      level = b;
      @(posedge clk);
      model_step(0, b);
      model_step(1, b);
      #1;
      check_both(tag);
   endtask

   task automatic run(input bit b, input int n, input string tag);
      for (int i = 0; i < n; i++) step(b, tag);
   endtask

   initial begin
      rst_n = 1'b0;
      level = 1'b0;
      model_reset();

      for (int i = 0; i < 5; i++) begin
         level = (i % 2 == 0);
         @(posedge clk);
         #1;
         check_both("reset_hold");
      end

      level = 1'b1;
      #3 rst_n = 1'b1;
      run(1'b1, 3, "press_at_reset_exit");
      run(1'b0, 10, "press_at_reset_exit_rel");

      run(1'b1, 3, "short_press");
      run(1'b0, 10, "short_press_rel");

      run(1'b1, 12, "long_press");
      run(1'b0, 10, "long_press_rel");

      run(1'b1, 2, "double_1st");
      run(1'b0, 3, "double_gap");
      run(1'b1, 2, "double_2nd");
      run(1'b0, 10, "double_rel");

      run(1'b1, 7, "press_7");
      run(1'b0, 10, "press_7_rel");

      run(1'b1, 2, "gap5_1st");
      run(1'b0, 5, "gap5_gap");
      run(1'b1, 2, "gap5_2nd");
      run(1'b0, 10, "gap5_rel");

      run(1'b1, 2, "gap6_1st");
      run(1'b0, 6, "gap6_gap");
      run(1'b1, 2, "gap6_2nd");
      run(1'b0, 10, "gap6_rel");

      run(1'b1, 1, "dbl_long_1st");
      run(1'b0, 2, "dbl_long_gap");
      run(1'b1, 12, "dbl_long_2nd");
      run(1'b0, 8, "dbl_long_rel");

      run(1'b1, 3, "rst_held_pre");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_both("async_rst_held");
      @(negedge clk) rst_n = 1'b1;
      run(1'b0, 4, "after_rst_held");

      run(1'b1, 2, "rst_wait2_press");
      run(1'b0, 3, "rst_wait2_gap");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_both("async_rst_wait2");
      @(negedge clk) rst_n = 1'b1;
      run(1'b0, 10, "after_rst_wait2");

      for (int g = 0; g < 60; g++) begin
         run(1'b1, int'($urandom_range(1, 12)), "rand_press");
         run(1'b0, int'($urandom_range(1, 9)), "rand_rel");
      end
      run(1'b0, 10, "final_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
